// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//   Universal shift register with parallel load, clear, logical/arithmetic
//   shifts and rotates. Shift/rotate ops repeat cnt times (0 counts as 1),
//   one step per clock. The first step happens on the accepting edge, and the
//   remaining steps run in the STEP state with busy high.
//
// Optional feature macro: USR_PARITY_EN (adds the 'parity' output)
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   en      in   operation request (taken only when idle and mode != hold)
//   mode    in   [2:0] op select: 000 hold, 001 load, 010 shl, 011 shr,
//                100 rol, 101 ror, 110 asr, 111 clear
//   cnt     in   [CNT_W-1:0] repeat count for shift/rotate (0 treated as 1)
//   d       in   [WIDTH-1:0] parallel load data
//   sin_l   in   serial input into the MSB on right shifts
//   sin_r   in   serial input into the LSB on left shifts
//   q       out  [WIDTH-1:0] register contents
//   busy    out  multi-step op in progress
//   done    out  one-cycle completion pulse
//   parity  out  XOR reduction of q (only with USR_PARITY_EN)
// ---------------------------------------------------------------------------
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {IDLE, STEP} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [2:0]       op_mode;

  // One single-bit step of a shift/rotate mode applied to a value.
  function automatic logic [WIDTH-1:0] step_q(input logic [2:0]       m,
                                              input logic [WIDTH-1:0] v,
                                              input logic             sl,
                                              input logic             sr);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      MODE_SHL: r = {v[WIDTH-2:0], sr};
      MODE_SHR: r = {sl, v[WIDTH-1:1]};
      MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROR: r = {v[0], v[WIDTH-1:1]};
      MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
      default:  r = v;
    endcase
    return r;
  endfunction

  // Control FSM and datapath. While in STEP the latched op_mode drives the
  // step and new requests are ignored; count holds the steps still to go,
  // so the step taken when count==1 is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      count   <= '0;
      op_mode <= MODE_HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (mode != MODE_HOLD)) begin
            case (mode)
              MODE_LOAD: begin
                q    <= d;
                done <= 1'b1;
              end
              MODE_CLEAR: begin
                q    <= '0;
                done <= 1'b1;
              end
              default: begin
                q       <= step_q(mode, q, sin_l, sin_r);
                op_mode <= mode;
                // cnt of 0 or 1 completes on this edge.
                if (cnt > ONE) begin
                  state <= STEP;
                  busy  <= 1'b1;
                  count <= cnt - ONE;
                end else begin
                  done <= 1'b1;
                end
              end
            endcase
          end
        end
        STEP: begin
          q     <= step_q(op_mode, q, sin_l, sin_r);
          count <= count - ONE;
          if (count == ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef USR_PARITY_EN
  // Combinational from q, so it is 0 whenever reset clears q.
  assign parity = ^q;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_reg
//   Directed-vector bench for universal_shift_reg (WIDTH=8, CNT_W=4).
//   Each issued op pushes its hand-computed final q into a queue; a monitor
//   pops and compares whenever done pulses. Intermediate and reset-state
//   values are compared directly by the stimulus thread.
// ---------------------------------------------------------------------------
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;
`endif

  int checks = 0;
  int fails  = 0;
  logic [WIDTH-1:0] exp_q[$];

  universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .cnt   (cnt),
    .d     (d),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .q     (q),
    .busy  (busy),
    .done  (done)
`ifdef USR_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every done pulse must match the oldest expected q.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_done: q=%h with no op pending", q);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (q !== e) begin
          fails++;
          $display("[TB] FAIL done_q: got %h expected %h", q, e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [2:0] m,
                               input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] dv,
                               input logic sl, input logic sr);
    en = e; mode = m; cnt = c; d = dv; sin_l = sl; sin_r = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the next edge, recording the final q it should produce.
  task automatic doOp(input logic [2:0] m, input logic [CNT_W-1:0] c,
                      input logic [WIDTH-1:0] dv, input logic sl, input logic sr,
                      input logic [WIDTH-1:0] expect_q);
    exp_q.push_back(expect_q);
    applyStimulus(1'b1, m, c, dv, sl, sr);
    tick();
    en = 1'b0;
  endtask

  // Bounded wait for the completion pulse.
  task automatic waitDone(input string name);
    int k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL %s_timeout: done=%b expected 1", name, done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, M_HOLD, '0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("reset_q", q, 8'h00);
    checkOutput("reset_busy", {7'd0, busy}, 8'h00);
    checkOutput("reset_done", {7'd0, done}, 8'h00);
`ifdef USR_PARITY_EN
    checkOutput("reset_parity", {7'd0, parity}, 8'h00);
`endif
    rst_n = 1'b1;

    // Load then hold with en=0 and with en=1/mode=hold.
    doOp(M_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5);
    checkOutput("load_q", q, 8'hA5);
    checkOutput("load_busy", {7'd0, busy}, 8'h00);
    applyStimulus(1'b0, M_LOAD, 4'd0, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_en0_q", q, 8'hA5);
      checkOutput("hold_en0_done", {7'd0, done}, 8'h00);
    end
    applyStimulus(1'b1, M_HOLD, 4'd3, 8'hFF, 1'b1, 1'b1);
    repeat (2) tick();
    checkOutput("hold_mode0_q", q, 8'hA5);
    checkOutput("hold_mode0_done", {7'd0, done}, 8'h00);
    en = 1'b0;

    // Async reset between edges.
    doOp(M_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0, 8'h5A);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_q", q, 8'h00);
    checkOutput("async_reset_busy", {7'd0, busy}, 8'h00);
    checkOutput("async_reset_done", {7'd0, done}, 8'h00);
    #1 rst_n = 1'b1;
    tick();

    // Shift left x3 with busy rejection, then clear on the done cycle.
    doOp(M_LOAD, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81);
    doOp(M_SHL, 4'd3, 8'h00, 1'b0, 1'b1, 8'h0F);
    checkOutput("shl_step1_q", q, 8'h03);
    checkOutput("shl_step1_busy", {7'd0, busy}, 8'h01);
    applyStimulus(1'b1, M_CLEAR, 4'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("shl_step2_q", q, 8'h07);
    checkOutput("shl_step2_busy", {7'd0, busy}, 8'h01);
    tick();
    checkOutput("shl_step3_q", q, 8'h0F);
    checkOutput("shl_step3_busy", {7'd0, busy}, 8'h00);
    checkOutput("shl_step3_done", {7'd0, done}, 8'h01);
    exp_q.push_back(8'h00);
    tick();
    en = 1'b0;
    checkOutput("b2b_clear_q", q, 8'h00);

    // Rotate right by 4, arithmetic shift right by 2.
    doOp(M_LOAD, 4'd0, 8'h12, 1'b0, 1'b0, 8'h12);
    doOp(M_ROR, 4'd4, 8'h00, 1'b0, 1'b0, 8'h21);
    waitDone("ror4");
    doOp(M_LOAD, 4'd0, 8'h80, 1'b0, 1'b0, 8'h80);
    doOp(M_ASR, 4'd2, 8'h00, 1'b0, 1'b0, 8'hE0);
    waitDone("asr2");

    // cnt=0 acts as a single step, no busy.
    doOp(M_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h3C);
    doOp(M_SHR, 4'd0, 8'h00, 1'b1, 1'b0, 8'h9E);
    checkOutput("shr_cnt0_busy", {7'd0, busy}, 8'h00);
    checkOutput("shr_cnt0_q", q, 8'h9E);

    // Counts at or beyond WIDTH.
    doOp(M_LOAD, 4'd0, 8'h96, 1'b0, 1'b0, 8'h96);
    doOp(M_ROL, 4'd9, 8'h00, 1'b0, 1'b0, 8'h2D);
    waitDone("rol9");
    doOp(M_CLEAR, 4'd0, 8'h55, 1'b0, 1'b0, 8'h00);
    doOp(M_SHL, 4'd10, 8'h00, 1'b0, 1'b1, 8'hFF);
    waitDone("shl10");

    // Abort a rotate mid-flight; no done may follow.
    doOp(M_LOAD, 4'd0, 8'h07, 1'b0, 1'b0, 8'h07);
`ifdef USR_PARITY_EN
    checkOutput("parity_07", {7'd0, parity}, 8'h01);
`endif
    applyStimulus(1'b1, M_ROR, 4'd6, 8'h00, 1'b0, 1'b0);
    tick();
    en = 1'b0;
    tick();
    checkOutput("abort_pre_q", q, 8'hC1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_q", q, 8'h00);
    checkOutput("abort_busy", {7'd0, busy}, 8'h00);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("post_abort_busy", {7'd0, busy}, 8'h00);
    end
    checkOutput("post_abort_q", q, 8'h00);

    // First op after reset release is taken on the first edge.
    doOp(M_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0, 8'h5A);
    checkOutput("first_after_reset_q", q, 8'h5A);
    repeat (2) tick();

    checkOutput("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, data register width in bits (>=2).
REQ-002 Parameter CNT_W, default 4, width of repeat-count input.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  operation request; sampled on rising clk edge.
REQ-006 mode  input  3  operation select (REQ-011).
REQ-007 cnt  input  CNT_W  repeat count for shift/rotate modes; 0 treated as 1.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_l / sin_r  input  1 each  serial-in into MSB (right shift) / LSB (left shift).
REQ-010 q  output WIDTH registered contents; busy output 1 multi-step op in progress; done output 1 one-cycle completion pulse.

Function
REQ-011 mode encoding: 000 hold, 001 parallel load d, 010 shift left (sin_r->LSB), 011 shift right logical (sin_l->MSB), 100 rotate left, 101 rotate right, 110 arithmetic shift right (MSB replicated), 111 clear to 0.
REQ-012 States: IDLE, STEP; reset state IDLE.
REQ-013 Op accepted only when en=1 and state IDLE and mode!=000; en=1 in STEP is ignored, with mode/cnt/d not re-sampled.
REQ-014 Load/clear: q updated on accepting edge; done=1 on that edge for exactly one cycle; busy stays 0.
REQ-015 Shift/rotate with effective count N: first step applied on accepting edge; if N>1, state->STEP, busy=1, internal counter=N-1.
REQ-016 In STEP, one step per clock using the latched mode; serial inputs sampled live each step; counter decrements per step.
REQ-017 Final step edge: state->IDLE, busy->0, done->1 for one cycle; q total latency N edges from accept.
REQ-018 N=1 behaves as REQ-014 (no busy).
REQ-019 New op may be accepted on the cycle done is high (back-to-back, no bubble).
REQ-020 en=0 or mode=000: q holds regardless of d/sin_l/sin_r; done=0.
REQ-021 N>=WIDTH permitted: shifts fill fully with serial/sign bits, rotates wrap modulo WIDTH naturally.

Reset
REQ-022 rst_n low forces q=0, busy=0, done=0, state IDLE, counter 0 immediately, independent of clk.
REQ-023 Reset during STEP aborts the op; no done pulse issued after reset release.
REQ-024 First op accepted on the first rising edge with rst_n high and en=1.

Configuration
REQ-025 Macro USR_PARITY_EN defined: extra output parity (1 bit) = XOR reduction of q, combinational from q, 0 in reset.
REQ-026 Macro USR_PARITY_EN undefined: parity port absent; all other behaviour identical.

Verification (WIDTH=8, CNT_W=4)
REQ-027 Reset: q loaded 8'h5A, drive rst_n=0 between edges -> q=8'h00, busy=0, done=0 before next edge.
REQ-028 Load/hold: en=1 mode=001 d=8'hA5 -> q=8'hA5, done=1 one cycle; then en=0 d=8'hFF 3 edges -> q stays 8'hA5.
REQ-029 Shift left q=8'h81 mode=010 cnt=3 sin_r=1 -> q 8'h03, 8'h07, 8'h0F on successive edges; busy high 2 cycles; done with final value.
REQ-030 Rotate right q=8'h12 mode=101 cnt=4 -> q=8'h21 after 4 edges; asr q=8'h80 mode=110 cnt=2 -> q=8'hE0.
REQ-031 Busy rejection: during REQ-029 op drive en=1 mode=111 -> ignored, final q=8'h0F; clear accepted on done cycle -> q=8'h00 next edge.
REQ-032 Abort: rst_n=0 mid rotate (cnt=6, after 2 steps) -> q=8'h00, busy=0, no done pulse after release; with USR_PARITY_EN, q=8'h07 -> parity=1.
